// File: rtl/rf_access_arbiter.sv
// Two-requester round-robin arbiter in front of a single register-file port.
// Each accepted access runs IDLE -> ACCESS -> RESP, with a timeout watchdog on the RF handshake.
module rf_access_arbiter #(
    parameter int HMC_RF_AWIDTH  = 4,
    parameter int HMC_RF_RWIDTH  = 64,
    parameter int HMC_RF_WWIDTH  = 64,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic                     req0_write,
    input  logic [HMC_RF_AWIDTH-1:0] req0_addr,
    input  logic [HMC_RF_WWIDTH-1:0] req0_wdata,

    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic                     req1_write,
    input  logic [HMC_RF_AWIDTH-1:0] req1_addr,
    input  logic [HMC_RF_WWIDTH-1:0] req1_wdata,

    output logic                     rsp0_valid,
    output logic [HMC_RF_RWIDTH-1:0] rsp0_rdata,
    output logic [1:0]               rsp0_status,

    output logic                     rsp1_valid,
    output logic [HMC_RF_RWIDTH-1:0] rsp1_rdata,
    output logic [1:0]               rsp1_status,

    output logic [HMC_RF_AWIDTH-1:0] rf_address,
    output logic [HMC_RF_WWIDTH-1:0] rf_write_data,
    output logic                     rf_read_en,
    output logic                     rf_write_en,
    input  logic [HMC_RF_RWIDTH-1:0] rf_read_data,
    input  logic                     rf_access_complete,
    input  logic                     rf_invalid_address,

    output logic                     busy
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] STATUS_OK       = 2'b00;
    localparam logic [1:0] STATUS_BAD_ADDR = 2'b01;
    localparam logic [1:0] STATUS_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic                     rr_ptr_q, rr_ptr_d;
    logic                     owner_q, owner_d;
    logic                     write_q, write_d;
    logic [HMC_RF_AWIDTH-1:0] addr_q, addr_d;
    logic [HMC_RF_WWIDTH-1:0] wdata_q, wdata_d;
    logic                     rd_en_q, rd_en_d;
    logic                     wr_en_q, wr_en_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [1:0]               rsp_valid_q, rsp_valid_d;
    logic [HMC_RF_RWIDTH-1:0] rsp_rdata_q  [2];
    logic [HMC_RF_RWIDTH-1:0] rsp_rdata_d  [2];
    logic [1:0]               rsp_status_q [2];
    logic [1:0]               rsp_status_d [2];

    logic                     any_valid;
    logic                     grant_id;
    logic                     accept;
    logic                     sel_write;
    logic [HMC_RF_AWIDTH-1:0] sel_addr;
    logic [HMC_RF_WWIDTH-1:0] sel_wdata;

    // The pointer only matters under contention; a lone requester always wins.
    assign any_valid = req0_valid | req1_valid;
    assign grant_id  = (req0_valid && req1_valid) ? rr_ptr_q : req1_valid;
    assign accept    = !rst && (state_q == ST_IDLE) && any_valid;

    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept &&  grant_id;

    assign sel_write = grant_id ? req1_write : req0_write;
    assign sel_addr  = grant_id ? req1_addr  : req0_addr;
    assign sel_wdata = grant_id ? req1_wdata : req0_wdata;

    always_comb begin
        // NOTE: every _d starts from its _q so no path through the case leaves a latch.
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_en_d      = rd_en_q;
        wr_en_d      = wr_en_q;
        cnt_d        = cnt_q;
        rsp_valid_d  = '0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_status_d = rsp_status_q;

        case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    owner_d  = grant_id;
                    rr_ptr_d = ~grant_id;
                    write_d  = sel_write;
                    addr_d   = sel_addr;
                    wdata_d  = sel_wdata;
                    rd_en_d  = !sel_write;
                    wr_en_d  = sel_write;
                    cnt_d    = '0;
                    state_d  = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                // Completion is checked first so a completion on the last allowed cycle wins.
                if (rf_access_complete) begin
                    rd_en_d                = 1'b0;
                    wr_en_d                = 1'b0;
                    rsp_valid_d[owner_q]   = 1'b1;
                    rsp_rdata_d[owner_q]   = write_q ? '0 : rf_read_data;
                    rsp_status_d[owner_q]  = rf_invalid_address ? STATUS_BAD_ADDR : STATUS_OK;
                    state_d                = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rd_en_d                = 1'b0;
                    wr_en_d                = 1'b0;
                    rsp_valid_d[owner_q]   = 1'b1;
                    rsp_rdata_d[owner_q]   = '0;
                    rsp_status_d[owner_q]  = STATUS_TIMEOUT;
                    state_d                = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                rd_en_d = 1'b0;
                wr_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: response data registers are reset too, since they drive outputs that must read 0 after reset.
        if (rst) begin
            state_q         <= ST_IDLE;
            rr_ptr_q        <= 1'b0;
            owner_q         <= 1'b0;
            write_q         <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            rd_en_q         <= 1'b0;
            wr_en_q         <= 1'b0;
            cnt_q           <= '0;
            rsp_valid_q     <= '0;
            rsp_rdata_q[0]  <= '0;
            rsp_rdata_q[1]  <= '0;
            rsp_status_q[0] <= '0;
            rsp_status_q[1] <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_en_q      <= rd_en_d;
            wr_en_q      <= wr_en_d;
            cnt_q        <= cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    assign rf_address    = addr_q;
    assign rf_write_data = wdata_q;
    assign rf_read_en    = rd_en_q;
    assign rf_write_en   = wr_en_q;
    assign busy          = (state_q != ST_IDLE);

    assign rsp0_valid  = rsp_valid_q[0];
    assign rsp1_valid  = rsp_valid_q[1];
    assign rsp0_rdata  = rsp_rdata_q[0];
    assign rsp1_rdata  = rsp_rdata_q[1];
    assign rsp0_status = rsp_status_q[0];
    assign rsp1_status = rsp_status_q[1];

    a_one_strobe: assert property (@(posedge clk) disable iff (rst)
        !(rf_read_en && rf_write_en));
    a_one_ready: assert property (@(posedge clk) disable iff (rst)
        !(req0_ready && req1_ready));

endmodule

// File: doc/rf_access_arbiter.md
RF_ACCESS_ARBITER -- requirements
Module: rf_access_arbiter

Interface
REQ-001 SHALL have parameter HMC_RF_AWIDTH, default 4, RF address width.
REQ-002 SHALL have parameter HMC_RF_RWIDTH, default 64, RF read data width.
REQ-003 SHALL have parameter HMC_RF_WWIDTH, default 64, RF write data width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 32, max cycles waiting for rf_access_complete.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 reqN_valid  in  1  requester N (N=0,1) access request.
REQ-008 reqN_ready  out  1  request N accepted this cycle.
REQ-009 reqN_write  in  1  1=write, 0=read.
REQ-010 reqN_addr  in  HMC_RF_AWIDTH  target register.
REQ-011 reqN_wdata  in  HMC_RF_WWIDTH  write data.
REQ-012 rspN_valid  out  1  one-cycle response pulse to requester N.
REQ-013 rspN_rdata  out  HMC_RF_RWIDTH  read data, valid with rspN_valid.
REQ-014 rspN_status  out  2  00 OK, 01 invalid address, 10 timeout.
REQ-015 rf_address  out  HMC_RF_AWIDTH  to RF.
REQ-016 rf_write_data  out  HMC_RF_WWIDTH  to RF.
REQ-017 rf_read_en / rf_write_en  out  1 each  RF strobes.
REQ-018 rf_read_data  in  HMC_RF_RWIDTH; rf_access_complete  in  1; rf_invalid_address  in  1.
REQ-019 busy  out  1  high whenever state is not IDLE.

Function
REQ-020 FSM states SHALL be IDLE, ACCESS, RESP.
REQ-021 IDLE: if any reqN_valid, grant one requester; granted reqN_ready SHALL be high combinationally that cycle, other ready low; latch write/addr/wdata and owner; next state ACCESS.
REQ-022 Arbitration SHALL be round-robin: pointer selects preferred requester when both valid; after each grant pointer = other requester; single valid requester always granted.
REQ-023 reqN_ready SHALL be 0 in ACCESS and RESP.
REQ-024 ACCESS: rf_address/rf_write_data SHALL hold latched values; exactly one of rf_read_en/rf_write_en (per latched write) SHALL be registered high from first ACCESS cycle until cycle after rf_access_complete sampled high.
REQ-025 Handshake latency: accept at cycle T -> strobe high T+1 -> complete sampled at T+k (k>=1) -> strobe low and rspN_valid high at T+k+1 (RESP) -> IDLE at T+k+2.
REQ-026 On complete, rspN_rdata SHALL capture rf_read_data for reads, 0 for writes; status 01 if rf_invalid_address sampled high with complete, else 00.
REQ-027 Timeout counter (width clog2(TIMEOUT_CYCLES)+1) SHALL clear on entering ACCESS, increment each ACCESS cycle without complete; at TIMEOUT_CYCLES cycles without complete, go RESP with status 10, rdata 0, strobes dropped.
REQ-028 Complete in same cycle as timeout threshold SHALL be treated as normal completion (complete wins).
REQ-029 rf_access_complete/rf_invalid_address SHALL be ignored in IDLE and RESP.
REQ-030 RESP: exactly one cycle, rspN_valid only to owner; rdata/status held stable until next response.
REQ-031 New grant SHALL NOT occur in RESP; earliest next accept is first IDLE cycle (back-to-back period k+2 cycles).

Reset
REQ-032 On rst: state IDLE, pointer 0, counter 0, all outputs 0 (ready, rsp valid/rdata/status, rf strobes, rf_address, rf_write_data, busy).
REQ-033 rst mid-ACCESS SHALL drop strobes at that edge and issue no response; later complete ignored.

Verification
REQ-034 Single read: req0 read addr 3; RF completes k=2 with 0xDEAD_BEEF -> rf_read_en high 2 cycles, rsp0_valid 1 cycle with rdata 0xDEADBEEF, status 00.
REQ-035 Both valid after reset -> req0 granted first, req1 next; repeated contention alternates 0,1,0,1.
REQ-036 Write addr 15 with rf_invalid_address=1 at complete -> rsp status 01, rdata 0, rf_write_en dropped next cycle.
REQ-037 No complete for 32 cycles -> strobe drops, status 10; complete arriving later ignored, no extra rsp.
REQ-038 Complete on 32nd ACCESS cycle -> status 00, not timeout.
REQ-039 rst asserted 1 cycle into ACCESS -> all outputs 0 next cycle, no rsp pulse, next request served normally.
